// File: rtl/uart_cmd_pkg.sv
// Shared types, character constants and hex helper for the UART command transmitter.
package uart_cmd_pkg;

    localparam int unsigned CMD_W = 8;
    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;

    localparam logic [7:0] CHR_SP = 8'h20;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;

    // Line formatter states, in emission order.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADR,
        ST_SP,
        ST_DAT,
        ST_CR,
        ST_LF
    } fmt_state_t;

    // Captured command request.
    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] data;
        logic             has_data;
    } cmd_req_t;

    // Lowercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + 8'(nib);
        else             return 8'h57 + 8'(nib);
    endfunction

endpackage

// File: rtl/uart_tx_serial.sv
// 8N1 byte serializer with a valid/ready byte input.
//   clk, rst_n    : clock, synchronous active-low reset
//   byte_data     : byte to send, taken when byte_valid & byte_ready
//   byte_valid    : byte offered by the formatter
//   byte_ready    : idle, or in the final cycle of a stop bit
//   tx            : serial line, idle high
//   tx_busy       : a frame is in progress
module uart_tx_serial #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int unsigned BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W  = 4;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_STOP  = BIT_W'(9);
    localparam logic [BIT_W-1:0]  BIT_D7    = BIT_W'(8);

    logic [BAUD_W-1:0] baud_q;
    logic [BIT_W-1:0]  bit_q;
    logic [7:0]        sh_q;
    logic              bit_end;

    assign bit_end    = (baud_q == BAUD_LAST);
    // Ready in the last stop-bit cycle so back-to-back frames have no gap.
    assign byte_ready = ~tx_busy | (bit_end & (bit_q == BIT_STOP));

    // Baud/bit counters and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else if (byte_valid && byte_ready) begin
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= byte_data;
        end else if (tx_busy) begin
            if (bit_end) begin
                baud_q <= '0;
                if (bit_q == BIT_STOP) begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    bit_q   <= '0;
                end else begin
                    bit_q <= bit_q + BIT_W'(1);
                    if (bit_q == BIT_D7) begin
                        tx <= 1'b1;
                    end else begin
                        tx   <= sh_q[0];
                        sh_q <= {1'b1, sh_q[7:1]};
                    end
                end
            end else begin
                baud_q <= baud_q + BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// Formats a command request as an ASCII line and sends it 8N1 on tx.
//   clk, rst_n    : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake; ready only while not busy
//   req_cmd, req_adr, req_data, req_has_data : request fields
//   tx            : serial output, idle high
//   busy          : a line is being formatted or transmitted
module uart_cmd_tx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CMD_W-1:0] req_cmd,
    input  logic [ADR_W-1:0] req_adr,
    input  logic [DAT_W-1:0] req_data,
    input  logic             req_has_data,
    output logic             tx,
    output logic             busy
);

    fmt_state_t state_q, state_d;
    logic [2:0] nib_q, nib_d;
    cmd_req_t   req_q;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       tx_busy;
    logic       accept;
    logic       xfer;
    logic       busy_d;
    logic [31:0] sel_word;
    logic [3:0] nibble;

    assign accept     = req_valid & req_ready;
    assign byte_valid = (state_q != ST_IDLE);
    assign xfer       = byte_valid & byte_ready;
    // Serializer stays busy if it takes a byte or is mid-frame.
    assign busy_d     = (state_d != ST_IDLE) | byte_valid | (tx_busy & ~byte_ready);

    // Nibble select: nib_q counts 7..0, MSB nibble first.
    assign sel_word = (state_q == ST_DAT) ? req_q.data : req_q.adr;
    assign nibble   = 4'(sel_word >> {nib_q, 2'b00});

    // Byte presented for the current formatter state.
    always_comb begin
        byte_data = '0;
        case (state_q)
            ST_CMD:  byte_data = req_q.cmd;
            ST_ADR:  byte_data = hex2ascii(nibble);
            ST_SP:   byte_data = CHR_SP;
            ST_DAT:  byte_data = hex2ascii(nibble);
            ST_CR:   byte_data = CHR_CR;
            ST_LF:   byte_data = CHR_LF;
            default: byte_data = '0;
        endcase
    end

    // Formatter next state; advances only on an accepted byte.
    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_CMD;
            ST_CMD: if (xfer) begin
                state_d = ST_ADR;
                nib_d   = 3'd7;
            end
            ST_ADR: if (xfer) begin
                if (nib_q == 3'd0) state_d = req_q.has_data ? ST_SP : ST_CR;
                else               nib_d   = nib_q - 3'd1;
            end
            ST_SP: if (xfer) begin
                state_d = ST_DAT;
                nib_d   = 3'd7;
            end
            ST_DAT: if (xfer) begin
                if (nib_q == 3'd0) state_d = ST_CR;
                else               nib_d   = nib_q - 3'd1;
            end
            ST_CR:   if (xfer) state_d = ST_LF;
            ST_LF:   if (xfer) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, capture and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            nib_q     <= '0;
            req_q     <= '0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            nib_q     <= nib_d;
            busy      <= busy_d;
            req_ready <= ~busy_d;
            if (accept) begin
                req_q.cmd      <= req_cmd;
                req_q.adr      <= req_adr;
                req_q.data     <= req_data;
                req_q.has_data <= req_has_data;
            end
        end
    end

    uart_tx_serial #(
        .CLK_DIV (CLK_DIV)
    ) u_serial (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Bench for uart_cmd_tx: driver pushes expected line bytes, a tx-line monitor decodes frames and compares.
module tb_uart_cmd_tx;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned FRAME   = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [31:0] req_adr;
    logic [31:0] req_data;
    logic        req_has_data;
    logic        tx;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    uart_cmd_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_adr      (req_adr),
        .req_data     (req_data),
        .req_has_data (req_has_data),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference line: command char, %08x hex fields, optional space + data, CR LF.
    function automatic void push_line(input logic [7:0] c, input logic [31:0] a,
                                      input logic [31:0] d, input bit hd);
        string s;
        exp_q.push_back(c);
        s = $sformatf("%08x", a);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (hd) begin
            exp_q.push_back(8'h20);
            s = $sformatf("%08x", d);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // Monitor: decodes frames on tx, checks every bit holds for CLK_DIV cycles.
    bit         mon_on = 1'b0;
    int         mon_t;
    logic [9:0] mon_val;
    bit         mon_glitch;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (tx == 1'b0) begin
                mon_on     = 1'b1;
                mon_t      = 1;
                mon_val    = '0;
                mon_glitch = 1'b0;
            end
        end else begin
            if (mon_t % CLK_DIV == 0) mon_val[mon_t / CLK_DIV] = tx;
            else if (tx !== mon_val[mon_t / CLK_DIV]) mon_glitch = 1'b1;
            mon_t++;
            if (mon_t == FRAME) begin
                mon_on = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {22'd0, mon_val}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("frame_byte", {20'd0, mon_glitch, mon_val[9], mon_val[8:1], 1'b0, mon_val[0]},
                        {20'd0, 1'b0, 1'b1, e, 1'b0, 1'b0});
                end
            end
        end
    end

    // Present a request at the current negedge and wait for acceptance; ends at cycle 1.
    task automatic start_req(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                             input bit hd, output int waited);
        req_cmd      = c;
        req_adr      = a;
        req_data     = d;
        req_has_data = hd;
        req_valid    = 1'b1;
        waited = 0;
        while (!req_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) chk("accept_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        push_line(c, a, d, hd);
        @(negedge clk);
        chk("busy_cycle1", {31'd0, busy}, 32'd1);
        chk("ready_cycle1", {31'd0, req_ready}, 32'd0);
    endtask

    // From cycle 1: check start-bit latency and busy fall time; optionally pulse a rejected request.
    task automatic finish_line(input int nbytes, input int pulse_at);
        int cyc;
        cyc = 1;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) chk("start_bit_cycle2", {31'd0, tx}, 32'd0);
            if (pulse_at > 0 && cyc == pulse_at) begin
                req_valid = 1'b1;
                req_adr   = 32'h5555_AAAA;
                chk("busy_reject_ready", {31'd0, req_ready}, 32'd0);
            end else if (pulse_at > 0 && cyc == pulse_at + 1) begin
                req_valid = 1'b0;
            end
            if (!busy || cyc >= 2000) break;
        end
        chk("line_length", 32'(cyc), 32'(2 + FRAME * nbytes));
        chk("ready_after_line", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] cmds[4];
        int w;
        bit stuck;
        cmds[0] = 8'h72; cmds[1] = 8'h77; cmds[2] = 8'h67; cmds[3] = 8'h64;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_cmd = '0; req_adr = '0; req_data = '0; req_has_data = 1'b0;

        // Reset state and idle line.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        stuck = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stuck = 1'b0;
        end
        chk("idle_1000", {31'd0, stuck}, 32'd1);

        // Read request without data.
        start_req(8'h72, 32'h0000_1234, 32'h0, 1'b0, w);
        req_valid = 1'b0;
        finish_line(11, 0);

        // Write request with data.
        start_req(8'h77, 32'hDEAD_BEEF, 32'h0123_ABCD, 1'b1, w);
        req_valid = 1'b0;
        finish_line(20, 0);

        // Back-to-back with req_valid held.
        start_req(8'h77, 32'h1000_0000, 32'hFFFF_FFFF, 1'b1, w);
        req_cmd = 8'h72; req_adr = 32'h89AB_CDEF; req_data = 32'h0; req_has_data = 1'b0;
        finish_line(20, 0);
        start_req(8'h72, 32'h89AB_CDEF, 32'h0, 1'b0, w);
        chk("b2b_no_gap", 32'(w), 32'd0);
        req_valid = 1'b0;
        finish_line(11, 0);

        // Request pulsed mid-line is rejected.
        start_req(8'h77, 32'h0000_00F0, 32'hCAFE_F00D, 1'b1, w);
        req_valid = 1'b0;
        finish_line(20, 300);

        // Reset during byte 5, then a fresh line.
        start_req(8'h77, 32'h1111_2222, 32'h3333_4444, 1'b1, w);
        req_valid = 1'b0;
        repeat (180) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_req(8'h67, 32'h0BAD_F00D, 32'h0, 1'b0, w);
        req_valid = 1'b0;
        finish_line(11, 0);

        // Random requests.
        for (int i = 0; i < 6; i++) begin
            logic [7:0]  c;
            logic [31:0] a, d;
            bit hd;
            c  = cmds[$urandom_range(3, 0)];
            a  = $urandom();
            d  = $urandom();
            hd = bit'($urandom_range(1, 0));
            start_req(c, a, d, hd, w);
            req_valid = 1'b0;
            finish_line(hd ? 20 : 11, 0);
        end

        repeat (10) @(negedge clk);
        chk("all_bytes_seen", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
